// File: rtl/bus_processor.sv
// bus_processor: 8-bit interrupt-driven processor. Fetches from a synchronous ROM
// and talks to memory-mapped slaves over a shared tristate bus.
module bus_processor #(
    parameter logic [7:0] VEC_A = 8'hFF,
    parameter logic [7:0] VEC_B = 8'hFE
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    output logic [7:0] ROM_ADDRESS,
    input  logic [7:0] ROM_DATA,
    input  logic [1:0] BUS_INTERRUPTS_RAISE,
    output logic [1:0] BUS_INTERRUPTS_ACK
);

    localparam int unsigned DW  = 8;
    localparam int unsigned IRW = 2;

    typedef enum logic [DW-1:0] {
        ST_CHOOSE    = 8'h00,
        ST_RD_A      = 8'h10,
        ST_RD_B      = 8'h11,
        ST_RD_ADDR   = 8'h12,
        ST_RD_WAIT   = 8'h13,
        ST_RD_LOAD   = 8'h14,
        ST_WR_A      = 8'h20,
        ST_WR_B      = 8'h21,
        ST_WR_ADDR   = 8'h22,
        ST_WR_END    = 8'h23,
        ST_ALU_A     = 8'h30,
        ST_ALU_B     = 8'h31,
        ST_ALU_WAIT  = 8'h32,
        ST_BR_WAIT   = 8'h40,
        ST_BR        = 8'h41,
        ST_BR_END    = 8'h42,
        ST_GO_WAIT   = 8'h50,
        ST_GO        = 8'h51,
        ST_GO_END    = 8'h52,
        ST_CALL_WAIT = 8'h60,
        ST_CALL      = 8'h61,
        ST_CALL_END  = 8'h62,
        ST_RET       = 8'h70,
        ST_RET_END   = 8'h71,
        ST_DR_A      = 8'h80,
        ST_DR_B      = 8'h81,
        ST_DR_WAIT   = 8'h82,
        ST_DR_LOAD   = 8'h83,
        ST_F1        = 8'hF1,
        ST_F2        = 8'hF2,
        ST_F3        = 8'hF3,
        ST_IDLE      = 8'hFF
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [DW-1:0]  ctx_q, ctx_d;
    logic [DW-1:0]  bus_addr_q, bus_addr_d;
    logic [DW-1:0]  bus_out_q, bus_out_d;
    logic           bus_we_q, bus_we_d;
    logic [IRW-1:0] ack_q, ack_d;
    logic [DW-1:0]  alu_res;
    logic [DW-1:0]  bus_in;

    assign BUS_DATA           = bus_we_q ? bus_out_q : {DW{1'bz}};
    assign bus_in             = BUS_DATA;
    assign BUS_ADDR           = bus_addr_q;
    assign BUS_WE             = bus_we_q;
    assign ROM_ADDRESS        = pc_q;
    assign BUS_INTERRUPTS_ACK = ack_q;

    // ALU selected by the upper opcode nibble; all results wrap to 8 bits
    always_comb begin
        alu_res = a_q;
        case (ir_q[7:4])
            4'h0:    alu_res = a_q + b_q;
            4'h1:    alu_res = a_q - b_q;
            4'h2:    alu_res = DW'(a_q * b_q);
            4'h3:    alu_res = a_q << 1;
            4'h4:    alu_res = a_q >> 1;
            4'h5:    alu_res = a_q + 8'd1;
            4'h6:    alu_res = b_q + 8'd1;
            4'h7:    alu_res = a_q - 8'd1;
            4'h8:    alu_res = b_q - 8'd1;
            4'h9:    alu_res = DW'(a_q == b_q);
            4'hA:    alu_res = DW'(a_q > b_q);
            4'hB:    alu_res = DW'(a_q < b_q);
            default: alu_res = a_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode dispatch uses ROM_DATA directly because IR is loaded on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (|BUS_INTERRUPTS_RAISE) state_d = ST_F1;
            ST_F1:        state_d = ST_F2;
            ST_F2:        state_d = ST_F3;
            ST_F3:        state_d = ST_CHOOSE;
            ST_CHOOSE: begin
                case (ROM_DATA[3:0])
                    4'h0:    state_d = ST_RD_A;
                    4'h1:    state_d = ST_RD_B;
                    4'h2:    state_d = ST_WR_A;
                    4'h3:    state_d = ST_WR_B;
                    4'h4:    state_d = ST_ALU_A;
                    4'h5:    state_d = ST_ALU_B;
                    4'h6:    state_d = ST_BR_WAIT;
                    4'h7:    state_d = ST_GO_WAIT;
                    4'h9:    state_d = ST_CALL_WAIT;
                    4'hA:    state_d = ST_RET;
                    4'hB:    state_d = ST_DR_A;
                    4'hC:    state_d = ST_DR_B;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_RD_A:      state_d = ST_RD_ADDR;
            ST_RD_B:      state_d = ST_RD_ADDR;
            ST_RD_ADDR:   state_d = ST_RD_WAIT;
            ST_RD_WAIT:   state_d = ST_RD_LOAD;
            ST_RD_LOAD:   state_d = ST_CHOOSE;
            ST_WR_A:      state_d = ST_WR_ADDR;
            ST_WR_B:      state_d = ST_WR_ADDR;
            ST_WR_ADDR:   state_d = ST_WR_END;
            ST_WR_END:    state_d = ST_CHOOSE;
            ST_ALU_A:     state_d = ST_ALU_WAIT;
            ST_ALU_B:     state_d = ST_ALU_WAIT;
            ST_ALU_WAIT:  state_d = ST_CHOOSE;
            ST_BR_WAIT:   state_d = ST_BR;
            ST_BR:        state_d = ST_BR_END;
            ST_BR_END:    state_d = ST_CHOOSE;
            ST_GO_WAIT:   state_d = ST_GO;
            ST_GO:        state_d = ST_GO_END;
            ST_GO_END:    state_d = ST_CHOOSE;
            ST_CALL_WAIT: state_d = ST_CALL;
            ST_CALL:      state_d = ST_CALL_END;
            ST_CALL_END:  state_d = ST_CHOOSE;
            ST_RET:       state_d = ST_RET_END;
            ST_RET_END:   state_d = ST_CHOOSE;
            ST_DR_A:      state_d = ST_DR_WAIT;
            ST_DR_B:      state_d = ST_DR_WAIT;
            ST_DR_WAIT:   state_d = ST_DR_LOAD;
            ST_DR_LOAD:   state_d = ST_CHOOSE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath updates; write strobe and ACK default low so each lasts one cycle
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        ctx_d      = ctx_q;
        bus_addr_d = bus_addr_q;
        bus_out_d  = bus_out_q;
        bus_we_d   = 1'b0;
        ack_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (BUS_INTERRUPTS_RAISE[0]) begin
                    ack_d = 2'b01;
                    pc_d  = VEC_A;
                end else if (BUS_INTERRUPTS_RAISE[1]) begin
                    ack_d = 2'b10;
                    pc_d  = VEC_B;
                end
            end
            ST_F2: pc_d = ROM_DATA;
            ST_CHOOSE: begin
                ir_d = ROM_DATA;
                pc_d = pc_q + 8'd1;
            end
            ST_RD_ADDR: begin
                bus_addr_d = ROM_DATA;
                pc_d       = pc_q + 8'd1;
            end
            ST_RD_LOAD: begin
                if (ir_q[0]) b_d = bus_in;
                else         a_d = bus_in;
            end
            ST_WR_ADDR: begin
                bus_addr_d = ROM_DATA;
                bus_out_d  = ir_q[0] ? b_q : a_q;
                bus_we_d   = 1'b1;
                pc_d       = pc_q + 8'd1;
            end
            ST_ALU_A: a_d = alu_res;
            ST_ALU_B: b_d = alu_res;
            ST_BR:    pc_d = (alu_res == 8'd1) ? ROM_DATA : pc_q + 8'd1;
            ST_GO:    pc_d = ROM_DATA;
            ST_CALL: begin
                ctx_d = pc_q + 8'd1;
                pc_d  = ROM_DATA;
            end
            ST_RET:  pc_d = ctx_q;
            ST_DR_A: bus_addr_d = a_q;
            ST_DR_B: bus_addr_d = b_q;
            ST_DR_LOAD: begin
                if (ir_q[3:0] == 4'hB) a_d = bus_in;
                else                   b_d = bus_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ctx_q      <= '0;
            bus_addr_q <= 8'hFF;
            bus_out_q  <= '0;
            bus_we_q   <= 1'b0;
            ack_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctx_q      <= ctx_d;
            bus_addr_q <= bus_addr_d;
            bus_out_q  <= bus_out_d;
            bus_we_q   <= bus_we_d;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: tb/tb_bus_processor.sv
// Bench for bus_processor: directed bring-up program, then a random program
// checked instruction by instruction against an instruction-level model.
module tb_bus_processor;

    logic       clk = 1'b0;
    logic       reset;
    tri1  [7:0] bus_data;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] rom_address;
    logic [7:0] rom_data;
    logic [1:0] raise;
    logic [1:0] ack;
    logic       sl_load;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom   [256];
    logic [7:0] smem  [256];
    logic [7:0] slv_q;
    logic       slv_drv_q;

    // Architectural model state
    logic [7:0] m_pc, m_a, m_b, m_ctx;
    logic [7:0] m_mem  [256];
    logic [7:0] sv_mem [256];
    logic [7:0] sv_a, sv_b, sv_ctx;

    bus_processor dut (
        .CLK                  (clk),
        .RESET                (reset),
        .BUS_DATA             (bus_data),
        .BUS_ADDR             (bus_addr),
        .BUS_WE               (bus_we),
        .ROM_ADDRESS          (rom_address),
        .ROM_DATA             (rom_data),
        .BUS_INTERRUPTS_RAISE (raise),
        .BUS_INTERRUPTS_ACK   (ack)
    );

    always #5 clk = ~clk;

    // Synchronous ROM and a slave that answers reads below D0 one cycle after the address
    always @(posedge clk) begin
        rom_data <= rom[rom_address];
        if (sl_load) begin
            for (int i = 0; i < 256; i++) smem[i] <= m_mem[i];
        end else if (bus_we === 1'b1) begin
            smem[bus_addr] <= bus_data;
        end
        slv_q     <= smem[bus_addr];
        slv_drv_q <= (bus_addr < 8'hD0);
    end
    assign bus_data = (slv_drv_q && !bus_we) ? slv_q : 8'hzz;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return p[7:0];
            4'h3:    return {a[6:0], 1'b0};
            4'h4:    return {1'b0, a[7:1]};
            4'h5:    return a + 8'd1;
            4'h6:    return b + 8'd1;
            4'h7:    return a - 8'd1;
            4'h8:    return b - 8'd1;
            4'h9:    return (a == b) ? 8'd1 : 8'd0;
            4'hA:    return (a > b) ? 8'd1 : 8'd0;
            4'hB:    return (a < b) ? 8'd1 : 8'd0;
            default: return a;
        endcase
    endfunction

    // Executes one instruction at m_pc; returns the cycle count from dispatch back to dispatch/idle
    task automatic model_step(output int cyc, output bit we, output logic [7:0] wa,
                              output logic [7:0] wd, output bit halt);
        logic [7:0] op, opd, nx;
        nx  = m_pc + 8'd1;
        op  = rom[m_pc];
        opd = rom[nx];
        we = 1'b0; wa = '0; wd = '0; halt = 1'b0; cyc = 1;
        case (op[3:0])
            4'h0: begin m_a = m_mem[opd]; m_pc = m_pc + 8'd2; cyc = 5; end
            4'h1: begin m_b = m_mem[opd]; m_pc = m_pc + 8'd2; cyc = 5; end
            4'h2: begin m_mem[opd] = m_a; we = 1'b1; wa = opd; wd = m_a; m_pc = m_pc + 8'd2; cyc = 4; end
            4'h3: begin m_mem[opd] = m_b; we = 1'b1; wa = opd; wd = m_b; m_pc = m_pc + 8'd2; cyc = 4; end
            4'h4: begin m_a = alu(op[7:4], m_a, m_b); m_pc = m_pc + 8'd1; cyc = 3; end
            4'h5: begin m_b = alu(op[7:4], m_a, m_b); m_pc = m_pc + 8'd1; cyc = 3; end
            4'h6: begin
                m_pc = (alu(op[7:4], m_a, m_b) == 8'd1) ? opd : m_pc + 8'd2;
                cyc  = 4;
            end
            4'h7: begin m_pc = opd; cyc = 4; end
            4'h9: begin m_ctx = m_pc + 8'd2; m_pc = opd; cyc = 4; end
            4'hA: begin m_pc = m_ctx; cyc = 3; end
            4'hB: begin m_a = m_mem[m_a]; m_pc = m_pc + 8'd1; cyc = 4; end
            4'hC: begin m_b = m_mem[m_b]; m_pc = m_pc + 8'd1; cyc = 4; end
            default: begin halt = 1'b1; m_pc = m_pc + 8'd1; cyc = 1; end
        endcase
    endtask

    // Runs the DUT through one instruction (starting at dispatch) and compares with the model
    task automatic run_instr(input string tag);
        int         cyc, exp_cyc, we_cnt;
        bit         exp_we, exp_halt;
        logic [7:0] exp_wa, exp_wd, seen_wa, seen_wd;
        model_step(exp_cyc, exp_we, exp_wa, exp_wd, exp_halt);
        cyc = 0; we_cnt = 0; seen_wa = '0; seen_wd = '0;
        do begin
            tick();
            cyc++;
            if (bus_we === 1'b1) begin
                we_cnt++;
                seen_wa = bus_addr;
                seen_wd = bus_data;
            end
        end while (dut.state_q !== 8'h00 && dut.state_q !== 8'hFF && cyc < 16);
        chki({tag, " cycles"}, cyc, exp_cyc);
        chk8({tag, " state"}, 8'(dut.state_q), exp_halt ? 8'hFF : 8'h00);
        chk8({tag, " pc"}, rom_address, m_pc);
        chk8({tag, " A"}, dut.a_q, m_a);
        chk8({tag, " B"}, dut.b_q, m_b);
        chki({tag, " we_cycles"}, we_cnt, exp_we ? 1 : 0);
        if (exp_we) begin
            chk8({tag, " waddr"}, seen_wa, exp_wa);
            chk8({tag, " wdata"}, seen_wd, exp_wd);
        end
    endtask

    // From IDLE: raise, then walk the fetch states; raise stays up to show it is ignored
    task automatic enter_irq(input string tag, input logic [1:0] r, input logic [1:0] exp_ack,
                             input logic [7:0] vec);
        raise = r;
        tick();
        chk8({tag, " F1 state"}, 8'(dut.state_q), 8'hF1);
        chk8({tag, " ack"}, 8'(ack), 8'(exp_ack));
        chk8({tag, " pc=vec"}, rom_address, vec);
        tick();
        chk8({tag, " F2 state"}, 8'(dut.state_q), 8'hF2);
        chk8({tag, " ack drop"}, 8'(ack), 8'h00);
        tick();
        chk8({tag, " F3 state"}, 8'(dut.state_q), 8'hF3);
        chk8({tag, " pc=rom[vec]"}, rom_address, rom[vec]);
        chk8({tag, " F3 ack"}, 8'(ack), 8'h00);
        tick();
        chk8({tag, " dispatch"}, 8'(dut.state_q), 8'h00);
        raise = 2'b00;
        m_pc = rom[vec];
    endtask

    int         n_rand, gc, kind;
    bit         gw, gh, two, rb;
    logic [7:0] gwa, gwd, op, opd;
    logic [3:0] hi;

    initial begin
        reset   = 1'b1;
        raise   = 2'b00;
        sl_load = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 8'h08;
            m_mem[i] = 8'($urandom);
        end
        m_mem[8'hC0] = 8'h5A;
        m_mem[8'hC1] = 8'h03;
        m_mem[8'hC2] = 8'h07;
        m_a = '0; m_b = '0; m_ctx = '0; m_pc = '0;

        // Directed program
        rom[8'hFF] = 8'h10;
        rom[8'hFE] = 8'h60;
        rom[8'h10] = 8'h00; rom[8'h11] = 8'hC0;
        rom[8'h12] = 8'h02; rom[8'h13] = 8'hD0;
        rom[8'h14] = 8'h01; rom[8'h15] = 8'hC1;
        rom[8'h16] = 8'h00; rom[8'h17] = 8'hC2;
        rom[8'h18] = 8'h04;
        rom[8'h19] = 8'h14;
        rom[8'h1A] = 8'h24;
        rom[8'h1B] = 8'h95;
        rom[8'h1C] = 8'hA6; rom[8'h1D] = 8'h30;
        rom[8'h30] = 8'h09; rom[8'h31] = 8'h50;
        rom[8'h32] = 8'h08;
        rom[8'h50] = 8'h65;
        rom[8'h51] = 8'h0A;

        tick(); tick(); tick();
        sl_load = 1'b0;
        reset   = 1'b0;
        chk8("reset pc", rom_address, 8'h00);
        chk8("reset A", dut.a_q, 8'h00);
        chk8("reset B", dut.b_q, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk8("idle state", 8'(dut.state_q), 8'hFF);
            chk8("idle bus_addr", bus_addr, 8'hFF);
            chk8("idle bus_we", 8'(bus_we), 8'h00);
            chk8("idle ack", 8'(ack), 8'h00);
            chk8("idle bus_data released", bus_data, 8'hFF);
        end

        enter_irq("irqA", 2'b11, 2'b01, 8'hFF);
        chk8("thread start pc", rom_address, 8'h10);

        run_instr("read A");
        chk8("read A value", dut.a_q, 8'h5A);
        chk8("read pc", rom_address, 8'h12);
        chk8("read bus_addr", bus_addr, 8'hC0);
        run_instr("write A");
        chk8("write bus_addr", bus_addr, 8'hD0);
        chk8("write bus released", bus_data, 8'hFF);
        chk8("slave got write", smem[8'hD0], 8'h5A);
        run_instr("read B");
        run_instr("read A 07");
        run_instr("alu add");
        chk8("alu add A", dut.a_q, 8'h0A);
        run_instr("alu sub");
        chk8("alu sub A", dut.a_q, 8'h07);
        run_instr("alu mul");
        chk8("alu mul A", dut.a_q, 8'h15);
        run_instr("alu eq");
        chk8("alu eq B", dut.b_q, 8'h00);
        run_instr("branch");
        chk8("branch taken pc", rom_address, 8'h30);
        run_instr("call");
        chk8("call pc", rom_address, 8'h50);
        run_instr("sub body");
        run_instr("return");
        chk8("return pc", rom_address, 8'h32);
        run_instr("halt");
        chk8("halt state", 8'(dut.state_q), 8'hFF);

        // Generate a forward-only random program at 60 using a private model run
        sv_a = m_a; sv_b = m_b; sv_ctx = m_ctx;
        for (int i = 0; i < 256; i++) sv_mem[i] = m_mem[i];
        m_pc   = 8'h60;
        n_rand = 0;
        while (m_pc < 8'hD8 && n_rand < 40) begin
            kind = int'($urandom_range(0, 5));
            hi   = 4'($urandom_range(0, 15));
            rb   = 1'($urandom_range(0, 1));
            opd  = 8'($urandom_range(0, 8'hCF));
            two  = 1'b1;
            case (kind)
                0: op = {hi, 3'b000, rb};
                1: op = {hi, 3'b001, rb};
                2: begin op = {hi, 3'b010, rb}; two = 1'b0; end
                3: begin
                    two = 1'b0;
                    if (rb && m_b < 8'hD0)       op = {hi, 4'hC};
                    else if (!rb && m_a < 8'hD0) op = {hi, 4'hB};
                    else                         op = {hi, 4'h4};
                end
                4: begin
                    if (rb) hi = 4'(9 + $urandom_range(0, 2));
                    op  = {hi, 4'h6};
                    opd = m_pc + 8'(2 + $urandom_range(1, 3));
                end
                default: begin
                    op  = {hi, 4'h7};
                    opd = m_pc + 8'(2 + $urandom_range(1, 3));
                end
            endcase
            rom[m_pc] = op;
            if (two) rom[8'(m_pc + 8'd1)] = opd;
            model_step(gc, gw, gwa, gwd, gh);
            n_rand++;
        end
        m_a = sv_a; m_b = sv_b; m_ctx = sv_ctx;
        for (int i = 0; i < 256; i++) m_mem[i] = sv_mem[i];

        enter_irq("irqB", 2'b10, 2'b10, 8'hFE);
        for (int i = 0; i <= n_rand; i++) run_instr("rand");
        chk8("rand end idle", 8'(dut.state_q), 8'hFF);

        // Reset arriving while a write is about to strobe
        rom[8'hFF] = 8'hF0;
        rom[8'hF0] = 8'h02;
        rom[8'hF1] = 8'hD4;
        enter_irq("irqA2", 2'b01, 2'b01, 8'hFF);
        for (int i = 0; i < 10 && dut.state_q !== 8'h22; i++) tick();
        chk8("reached write addr state", 8'(dut.state_q), 8'h22);
        reset = 1'b1;
        tick();
        chk8("abort bus_we", 8'(bus_we), 8'h00);
        chk8("abort state", 8'(dut.state_q), 8'hFF);
        chk8("abort bus_addr", bus_addr, 8'hFF);
        chk8("abort pc", rom_address, 8'h00);
        reset = 1'b0;
        tick();
        chk8("post abort bus_we", 8'(bus_we), 8'h00);
        chk8("post abort bus released", bus_data, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
